// File: rtl/walk_request_bank.sv
// Multi-channel walk request latch with round-robin presentation to the controller.
// Define WALK_REQ_DEBOUNCE_EN to add per-channel debounce counters.
module walk_request_bank #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int ID_W     = 2
) (
  input  logic                clk,
  input  logic                sys_reset,
  input  logic [CHANNELS-1:0] walkRequest_in,
  input  logic [CHANNELS-1:0] walkRegister_reset,
  input  logic                req_ack,
  output logic [CHANNELS-1:0] walkRegister_status,
  output logic                req_valid,
  output logic [ID_W-1:0]     req_id,
  output logic [ID_W:0]       pending_count
);

  if (CHANNELS < 1 || CHANNELS > 16 ||
      DEBOUNCE < 1 || DEBOUNCE > 255 ||
      ID_W != ((CHANNELS > 1) ? $clog2(CHANNELS) : 1))
  begin : gBadParams
    $error("walk_request_bank: illegal parameters");
  end

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] armed;
  logic [CHANNELS-1:0] qualified;
  logic [CHANNELS-1:0] ackClr;
  logic [CHANNELS-1:0] pendingNext;
  logic [CHANNELS-1:0] armedNext;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     ptrNext;
  logic                found;
  logic                ackTake;

`ifdef WALK_REQ_DEBOUNCE_EN
  localparam logic [7:0] DbMax = 8'(DEBOUNCE);

  logic [7:0] dbCnt [CHANNELS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (sys_reset || walkRegister_reset[i] ||
          !walkRequest_in[i]) begin
        dbCnt[i] <= '0;
      end else if (dbCnt[i] != DbMax) begin
        dbCnt[i] <= dbCnt[i] + 8'd1;
      end
    end
  end

  // Qualify on the edge where the count reaches DbMax.
  always_comb begin
    qualified = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      qualified[i] = walkRequest_in[i] &&
                     (dbCnt[i] == DbMax - 8'd1);
    end
  end
`else
  assign qualified = walkRequest_in;
`endif

  // First pending channel at or after ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  assign req_valid = |pending;
  assign req_id    = sel;
  assign ackTake   = req_ack && req_valid;
  assign ptrNext   = (sel == ID_W'(CHANNELS - 1)) ?
                     '0 : sel + ID_W'(1);

  always_comb begin
    ackClr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ackClr[i] = ackTake && (sel == ID_W'(i));
    end
  end

  // Clears beat sets; a set attempt always disarms.
  always_comb begin
    pendingNext = pending;
    armedNext   = armed;
    for (int i = 0; i < CHANNELS; i++) begin
      if (walkRegister_reset[i] || ackClr[i]) begin
        pendingNext[i] = 1'b0;
      end else if (qualified[i] && armed[i]) begin
        pendingNext[i] = 1'b1;
      end
      if (!walkRequest_in[i]) begin
        armedNext[i] = 1'b1;
      end else if (qualified[i] && armed[i]) begin
        armedNext[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      pending <= '0;
      armed   <= '1;
      ptr     <= '0;
    end else begin
      pending <= pendingNext;
      armed   <= armedNext;
      if (ackTake) ptr <= ptrNext;
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pending_count = pending_count +
                      (ID_W+1)'(pending[i]);
    end
  end

  assign walkRegister_status = pending;

endmodule

// File: doc/walk_request_bank.md
# walk_request_bank

Multi-channel successor to the single pedestrian walk latch. It captures up to CHANNELS push-button requests, optionally debounced, each as a sticky pending bit. A round-robin arbiter presents one pending request at a time to the traffic-light controller FSM, which retires it with an acknowledge. The block sits between the crossing push-button inputs and the controller's walk-phase sequencing logic.

## Interface
- CHANNELS, default 4: number of walk-request channels (1..16).
- DEBOUNCE, default 3: consecutive high samples required to qualify a request (1..255); used only with the debounce feature compiled in.
- ID_W, default 2: width of req_id; must equal max(1, ceil(log2(CHANNELS))).

- clk  input  1  system clock; all state updates on the rising edge.
- sys_reset  input  1  synchronous, active-high reset; clears all state.
- walkRequest_in  input  CHANNELS  raw push-button level per channel.
- walkRegister_reset  input  CHANNELS  per-channel synchronous clear of pending and debounce state.
- req_ack  input  1  controller retires the currently presented request.
- walkRegister_status  output  CHANNELS  sticky pending bit per channel.
- req_valid  output  1  at least one channel is pending.
- req_id  output  ID_W  channel currently presented; valid only while req_valid.
- pending_count  output  ID_W+1  number of pending channels.

## Operation
- Per-channel state: pending bit, armed bit, debounce counter (8 bits, saturating at DEBOUNCE).
- Qualification: the counter increments while walkRequest_in[i]=1 and resets to 0 when it is 0. The channel is qualified on the cycle the counter reaches DEBOUNCE.
- Arming: armed[i] sets while walkRequest_in[i]=0. On a qualified, armed channel: pending[i] is set and armed[i] is cleared. A button held high therefore produces exactly one request; it must be released before another request can register.
- Pending is sticky until cleared by req_ack (presented channel only), walkRegister_reset[i], or sys_reset.
- Priority per channel, highest first: sys_reset > walkRegister_reset[i] > ack clear > set. A clear and a set on the same cycle leave pending=0 and armed=0.
- Arbiter: a round-robin pointer ptr selects the first pending channel at index ptr, ptr+1, … wrapping modulo CHANNELS. req_valid=|pending; req_id is the selected index, combinational from registered state.
- On req_ack with req_valid=1: pending[req_id] clears and ptr becomes (req_id+1) mod CHANNELS. A req_ack with req_valid=0 is ignored; ptr is unchanged.
- pending_count is the population count of the pending bits, derived combinationally.

## Timing
- Reset values: walkRegister_status=0, req_valid=0, req_id=0, pending_count=0, ptr=0, counters=0, armed=all 1.
- Request latency with debounce: the input rises at cycle 0 and is sampled high for DEBOUNCE edges. pending is visible after the DEBOUNCE-th rising edge.
- req_valid and req_id follow pending with zero added latency.
- Ack: the pending bit clears, and the arbiter moves to the next channel, on the edge at which req_ack=1 is sampled. A back-to-back ack on the next cycle retires the next channel.
- sys_reset asserted mid-request discards partial debounce counts. Inputs held high through reset register only after release and re-press, except that armed resets to 1: a level already high when reset deasserts registers after DEBOUNCE cycles.

## Configuration
- WALK_REQ_DEBOUNCE_EN defined: debounce counters are instantiated and behave as described above.
- WALK_REQ_DEBOUNCE_EN undefined: counters are removed. A channel is qualified on any cycle with walkRequest_in[i]=1 (1-cycle latency). Arming and clear priority are unchanged, and DEBOUNCE is ignored.

## Test plan
- Debounce (DEBOUNCE=3, ch1): input high 2 cycles, low, then high 3 cycles -> no pending after the 2-cycle pulse; pending[1]=1 after the third high edge; req_valid=1, req_id=1, pending_count=1.
- Round robin: pend ch0, ch2, ch3 with ptr=0; ack three times back to back -> req_id sequence 0, 2, 3; ptr ends at 0; req_valid=0 after the third ack.
- Hold-no-repeat: ch2 held high 20 cycles, acked at cycle 10 -> exactly one request; no re-pend until release plus re-press.
- Simultaneous: walkRegister_reset[0]=1 on the qualifying cycle of ch0 -> pending[0] stays 0. Ack of ch1 on the same cycle ch3 qualifies -> pending={1000}, req_id=3.
- Stray ack and reset: req_ack with nothing pending -> no state change. sys_reset with 4 channels pending -> all outputs 0 on the next cycle.
- Macro off: a 1-cycle pulse on ch3 -> pending[3]=1 on the next edge.
